eth_rx_frame_fifo_64: RTL and testbench

Store-and-forward frame FIFO placed directly downstream of the 64-bit XGMII receiver. It absorbs the receiver's AXI-stream output, which has no backpressure, and buffers whole frames. It commits a frame to the read side only once its `tlast` beat is stored, and presents frames on an AXI-stream master with full `tready` backpressure. Frames that overflow the buffer are discarded whole and never appear partially at the output.

---
 rtl/eth_rx_frame_fifo_64_if.sv | 18 +
 rtl/eth_rx_frame_fifo_64.sv | 151 +++++++++++++++
 tb/tb_eth_rx_frame_fifo_64.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_frame_fifo_64_if.sv
// AXI-stream bundle used on both sides of the RX frame FIFO.
// master: drives data/valid/last/user and samples tready.
// slave:  samples data/valid/last/user and drives tready.
interface eth_rx_frame_fifo_64_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_fifo_64.sv
// Store-and-forward frame FIFO behind the 64-bit XGMII receiver.
// Frames are written speculatively and only become visible to the read side
// once their tlast beat is stored; frames that do not fit are dropped whole.
// Optional macro ETH_RX_FIFO_DROP_BAD_EN: also discard frames whose tlast
// beat carries tuser[0]=1 instead of forwarding them with the error flag.
module eth_rx_frame_fifo_64 #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    eth_rx_frame_fifo_64_if.slave         s_axis,
    eth_rx_frame_fifo_64_if.master        m_axis,
    output logic                          status_overflow_o,
    output logic                          status_bad_frame_o,
    output logic                          status_good_frame_o
);
    localparam int WORD_W = USER_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [0:0] {ST_WRITE, ST_DROP} wr_state_e;

    logic [WORD_W-1:0]   ram_q [DEPTH];
    logic [WORD_W-1:0]   m_word_q;
    logic                m_valid_q;

    wr_state_e           state_q, state_d;
    logic [ADDR_WIDTH:0] wr_ptr_cur_q, wr_ptr_cur_d;
    logic [ADDR_WIDTH:0] wr_ptr_commit_q, wr_ptr_commit_d;
    logic [ADDR_WIDTH:0] rd_ptr_q;
    logic                ovf_q, ovf_d;
    logic                bad_q, bad_d;
    logic                good_q, good_d;
    logic                wr_en;
    logic                full, empty, rd_en, bad_in;

    // The receiver cannot be stalled; every beat is either stored or dropped.
    assign s_axis.tready = 1'b1;

    // Occupancy is judged on registered pointers only, so a read in the
    // current cycle frees space from the next cycle on.
    assign full   = (wr_ptr_cur_q - rd_ptr_q) == FULL_CNT;
    assign empty  = rd_ptr_q == wr_ptr_commit_q;
    assign bad_in = s_axis.tuser[0];

    // Write-side state and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_WRITE;
            wr_ptr_cur_q    <= '0;
            wr_ptr_commit_q <= '0;
            ovf_q           <= 1'b0;
            bad_q           <= 1'b0;
            good_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_cur_q    <= wr_ptr_cur_d;
            wr_ptr_commit_q <= wr_ptr_commit_d;
            ovf_q           <= ovf_d;
            bad_q           <= bad_d;
            good_q          <= good_d;
        end
    end

    // Next write state: an overflow mid-frame discards the rest of the frame.
    always_comb begin
        state_d = state_q;
        if (s_axis.tvalid) begin
            case (state_q)
                ST_WRITE: if (full && !s_axis.tlast) state_d = ST_DROP;
                ST_DROP:  if (s_axis.tlast)          state_d = ST_WRITE;
                default:  state_d = ST_WRITE;
            endcase
        end
    end

    // Write enable, pointer updates and status pulse requests.
    always_comb begin
        wr_en           = 1'b0;
        wr_ptr_cur_d    = wr_ptr_cur_q;
        wr_ptr_commit_d = wr_ptr_commit_q;
        ovf_d           = 1'b0;
        bad_d           = 1'b0;
        good_d          = 1'b0;
        if (s_axis.tvalid) begin
            bad_d = s_axis.tlast && bad_in;
            if (state_q == ST_WRITE) begin
                if (full) begin
                    // No room: rewind to the last committed frame boundary.
                    wr_ptr_cur_d = wr_ptr_commit_q;
                    ovf_d        = 1'b1;
                end else begin
                    wr_en        = 1'b1;
                    wr_ptr_cur_d = wr_ptr_cur_q + PTR_ONE;
                    if (s_axis.tlast) begin
`ifdef ETH_RX_FIFO_DROP_BAD_EN
                        if (bad_in) begin
                            wr_ptr_cur_d = wr_ptr_commit_q;
                        end else begin
                            wr_ptr_commit_d = wr_ptr_cur_q + PTR_ONE;
                            good_d          = 1'b1;
                        end
`else
                        wr_ptr_commit_d = wr_ptr_cur_q + PTR_ONE;
                        good_d          = !bad_in;
`endif
                    end
                end
            end
        end
    end

    // Frame buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            ram_q[wr_ptr_cur_q[ADDR_WIDTH-1:0]] <=
                {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    end

    // Registered RAM read doubles as the output register; refill it whenever
    // it is empty or its word is being taken this cycle.
    assign rd_en = !empty && (!m_valid_q || m_axis.tready);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            m_valid_q <= 1'b0;
            m_word_q  <= '0;
        end else if (rd_en) begin
            m_word_q  <= ram_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            m_valid_q <= 1'b1;
            rd_ptr_q  <= rd_ptr_q + PTR_ONE;
        end else if (m_axis.tready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_axis.tdata  = m_word_q[DATA_WIDTH-1:0];
    assign m_axis.tkeep  = m_word_q[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis.tlast  = m_word_q[DATA_WIDTH + KEEP_WIDTH];
    assign m_axis.tuser  = m_word_q[WORD_W-1 -: USER_WIDTH];
    assign m_axis.tvalid = m_valid_q;

    assign status_overflow_o   = ovf_q;
    assign status_bad_frame_o  = bad_q;
    assign status_good_frame_o = good_q;
endmodule

// File: tb/tb_eth_rx_frame_fifo_64.sv
// Self-checking bench for eth_rx_frame_fifo_64 with a 16-word buffer.
// Reference model: a frame of at most DEPTH beats offered to an empty buffer
// is delivered verbatim (unless it is bad and bad frames are dropped); a
// longer frame is dropped whole with a single overflow pulse.
module tb_eth_rx_frame_fifo_64;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef ETH_RX_FIFO_DROP_BAD_EN
    localparam bit DROP_BAD = 1'b1;
`else
    localparam bit DROP_BAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st_ovf, st_bad, st_good;
    always #5 clk = ~clk;

    eth_rx_frame_fifo_64_if #(.DATA_WIDTH(64)) s_if ();
    eth_rx_frame_fifo_64_if #(.DATA_WIDTH(64)) m_if ();

    eth_rx_frame_fifo_64 #(.ADDR_WIDTH(AW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis              (s_if),
        .m_axis              (m_if),
        .status_overflow_o   (st_ovf),
        .status_bad_frame_o  (st_bad),
        .status_good_frame_o (st_good)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 0;  // 0 always ready, 1 toggle, 2 held low, 3 random
    int ovf_cnt, bad_cnt, good_cnt, stall_viol, first_vld_cyc, last_in_cyc;
    bit stall_pend = 0;
    logic [73:0] held;
    logic [73:0] got_q[$];
    logic [73:0] exp_q[$];
    logic [73:0] frm[$];
    logic [73:0] f1[$];

    function automatic logic [73:0] out_word();
        return {m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata};
    endfunction

    // One clock: inputs are set at the falling edge before the call; outputs
    // are recorded here, handshakes judged with the tready just applied.
    task automatic tick();
        case (rdy_mode)
            0: m_if.tready = 1'b1;
            1: m_if.tready = (cyc % 2) == 0;
            2: m_if.tready = 1'b0;
            default: m_if.tready = 1'($urandom_range(0, 1));
        endcase
        if (m_if.tvalid && m_if.tready) got_q.push_back(out_word());
        if (stall_pend && out_word() !== held) stall_viol++;
        stall_pend = m_if.tvalid && !m_if.tready;
        held = out_word();
        if (s_if.tvalid && s_if.tlast) last_in_cyc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (m_if.tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
        ovf_cnt  += int'(st_ovf);
        bad_cnt  += int'(st_bad);
        good_cnt += int'(st_good);
    endtask

    task automatic clear();
        got_q.delete(); exp_q.delete();
        ovf_cnt = 0; bad_cnt = 0; good_cnt = 0; stall_viol = 0;
        first_vld_cyc = -1; last_in_cyc = -1;
    endtask

    task automatic make_frame(input int len, input bit bad);
        logic [7:0] k;
        frm.delete();
        for (int i = 0; i < len; i++) begin
            k = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
            frm.push_back({(i == len - 1) ? bad : 1'b0, i == len - 1, k,
                           32'($urandom), 32'($urandom)});
        end
    endtask

    task automatic send();
        foreach (frm[i]) begin
            s_if.tvalid = 1'b1;
            {s_if.tuser, s_if.tlast, s_if.tkeep, s_if.tdata} = frm[i];
            tick();
        end
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); rdy_mode = 0; clear();
        drain(3);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", m_if.tvalid); end
        checks++; if (out_word() !== 74'd0) begin errors++; $display("FAIL reset_word: got %h need 0", out_word()); end
        checks++; if ({st_ovf, st_bad, st_good} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b need 000", {st_ovf, st_bad, st_good}); end
        rst = 1'b0;
        drain(2);
    endtask

    task automatic test_single_frame();
        rdy_mode = 0; clear();
        make_frame(8, 1'b0); send(); idle(); drain(12);
        exp_q = frm;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_len: got %0d need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        // tlast accepted at the edge ending cycle N; first valid in N+2.
        checks++; if (first_vld_cyc !== last_in_cyc + 1) begin errors++; $display("FAIL single_latency: first valid cyc %0d need %0d", first_vld_cyc, last_in_cyc + 1); end
        checks++; if (good_cnt !== 1 || bad_cnt !== 0 || ovf_cnt !== 0) begin errors++; $display("FAIL single_status: good/bad/ovf %0d/%0d/%0d need 1/0/0", good_cnt, bad_cnt, ovf_cnt); end
    endtask

    task automatic test_bad_frame();
        rdy_mode = 0; clear();
        make_frame(8, 1'b1); send(); idle(); drain(12);
        if (!DROP_BAD) exp_q = frm;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bad_len: got %0d need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bad_beat%0d: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (bad_cnt !== 1 || good_cnt !== 0 || ovf_cnt !== 0) begin errors++; $display("FAIL bad_status: bad/good/ovf %0d/%0d/%0d need 1/0/0", bad_cnt, good_cnt, ovf_cnt); end
    endtask

    task automatic test_overflow();
        rdy_mode = 0; clear();
        make_frame(20, 1'b0); send(); idle(); drain(10);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ovf_len: got %0d need 0", got_q.size()); end
        checks++; if (ovf_cnt !== 1 || good_cnt !== 0) begin errors++; $display("FAIL ovf_status: ovf/good %0d/%0d need 1/0", ovf_cnt, good_cnt); end
        clear();
        make_frame(4, 1'b0); send(); idle(); drain(10);
        exp_q = frm;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_next_len: got %0d need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_next_beat%0d: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (good_cnt !== 1 || ovf_cnt !== 0) begin errors++; $display("FAIL ovf_next_status: good/ovf %0d/%0d need 1/0", good_cnt, ovf_cnt); end
    endtask

    task automatic test_back_to_back();
        rdy_mode = 2; clear();
        make_frame(10, 1'b0); f1 = frm; send();
        make_frame(10, 1'b0); send(); idle();
        drain(5);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL b2b_stalled: got %0d beats need 0", got_q.size()); end
        rdy_mode = 0; drain(20);
        exp_q = f1;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_len: got %0d need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (ovf_cnt !== 1 || good_cnt !== 1) begin errors++; $display("FAIL b2b_status: ovf/good %0d/%0d need 1/1", ovf_cnt, good_cnt); end
    endtask

    task automatic test_stall_toggle();
        rdy_mode = 1; clear();
        make_frame(16, 1'b0); send(); idle(); drain(60);
        exp_q = frm;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL toggle_len: got %0d need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL toggle_beat%0d: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL toggle_stable: %0d changes while stalled, need 0", stall_viol); end
    endtask

    task automatic test_reset_midframe();
        rdy_mode = 0; clear();
        make_frame(8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            s_if.tvalid = 1'b1;
            {s_if.tuser, s_if.tlast, s_if.tkeep, s_if.tdata} = frm[i];
            rst = (i == 2);
            tick();
        end
        rst = 1'b0; idle(); drain(12);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rstmid_len: got %0d need 0", got_q.size()); end
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b need 0", m_if.tvalid); end
        clear();
        make_frame(8, 1'b0); send(); idle(); drain(12);
        exp_q = frm;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_next_len: got %0d need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_next_beat%0d: got %h need %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int len;
        bit bad, fits;
        for (int n = 0; n < 16; n++) begin
            len = $urandom_range(1, 20);
            bad = ($urandom_range(0, 3) == 0);
            rdy_mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
            clear();
            make_frame(len, bad); send(); idle(); drain(120);
            fits = (len <= DEPTH);
            if (fits && !(DROP_BAD && bad)) exp_q = frm;
            checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d need %0d (len %0d bad %0d)", n, got_q.size(), exp_q.size(), len, bad); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_beat%0d: got %h need %h", n, i, got_q[i], exp_q[i]); end
            end
            checks++; if (ovf_cnt !== int'(!fits) || bad_cnt !== int'(bad) || good_cnt !== int'(fits && !bad)) begin
                errors++; $display("FAIL rand%0d_status: ovf/bad/good %0d/%0d/%0d need %0d/%0d/%0d", n, ovf_cnt, bad_cnt, good_cnt, !fits, bad, fits && !bad);
            end
        end
    endtask

    initial begin
        idle();
        s_if.tdata = '0; s_if.tkeep = '0;
        m_if.tready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_bad_frame();
        test_overflow();
        test_back_to_back();
        test_stall_toggle();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
